// File: rtl/mem_req_arbiter_if.sv
// Bus bundle for the two-client memory arbiter: icache, dcache and the single
// external memory port. The slave modport is the arbiter's view; the master
// modport is the surrounding environment (clients plus memory).
interface mem_req_arbiter_if #(
    parameter int unsigned ADDR_BITS = 28,
    parameter int unsigned DATA_BITS = 128,
    parameter int unsigned TAG_BITS  = 5
);
    localparam int unsigned MaskBits = DATA_BITS / 8;

    // icache client
    logic                 ic_req_valid;
    logic                 ic_req_ready;
    logic                 ic_req_rw;
    logic [ADDR_BITS-1:0] ic_req_addr;
    logic [TAG_BITS-2:0]  ic_req_tag;
    logic                 ic_req_data_valid;
    logic                 ic_req_data_ready;
    logic [DATA_BITS-1:0] ic_req_data_bits;
    logic [MaskBits-1:0]  ic_req_data_mask;
    logic                 ic_resp_valid;
    logic [TAG_BITS-2:0]  ic_resp_tag;
    logic [DATA_BITS-1:0] ic_resp_data;

    // dcache client
    logic                 dc_req_valid;
    logic                 dc_req_ready;
    logic                 dc_req_rw;
    logic [ADDR_BITS-1:0] dc_req_addr;
    logic [TAG_BITS-2:0]  dc_req_tag;
    logic                 dc_req_data_valid;
    logic                 dc_req_data_ready;
    logic [DATA_BITS-1:0] dc_req_data_bits;
    logic [MaskBits-1:0]  dc_req_data_mask;
    logic                 dc_resp_valid;
    logic [TAG_BITS-2:0]  dc_resp_tag;
    logic [DATA_BITS-1:0] dc_resp_data;

    // external memory port
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_req_data_valid;
    logic                 mem_req_data_ready;
    logic [DATA_BITS-1:0] mem_req_data_bits;
    logic [MaskBits-1:0]  mem_req_data_mask;
    logic                 mem_resp_valid;
    logic [TAG_BITS-1:0]  mem_resp_tag;
    logic [DATA_BITS-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_rw, ic_req_addr, ic_req_tag,
        input  ic_req_data_valid, ic_req_data_bits, ic_req_data_mask,
        output ic_req_ready, ic_req_data_ready, ic_resp_valid, ic_resp_tag, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_tag,
        input  dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        output dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_tag, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_rw, ic_req_addr, ic_req_tag,
        output ic_req_data_valid, ic_req_data_bits, ic_req_data_mask,
        input  ic_req_ready, ic_req_data_ready, ic_resp_valid, ic_resp_tag, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_tag,
        output dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        input  dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_tag, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_tag, mem_resp_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between icache (id 0) and dcache (id 1) onto a single
// memory port. Writes lock the data channel to the granted client for WR_BEATS
// beats; responses are steered back by the tag MSB with zero latency.
// Optional macro MEM_ARB_PERF_EN adds 32-bit grant/conflict counters.
module mem_req_arbiter #(
    parameter int unsigned ADDR_BITS = 28,
    parameter int unsigned DATA_BITS = 128,
    parameter int unsigned TAG_BITS  = 5,
    parameter int unsigned WR_BEATS  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_req_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_ic_grants,
    output logic [31:0]        perf_dc_grants,
    output logic [31:0]        perf_conflict_cycles
`endif
);

    localparam int unsigned CntBits  = $clog2(WR_BEATS + 1);
    localparam int unsigned MaskBits = DATA_BITS / 8;
    localparam logic [CntBits-1:0] LastBeat = CntBits'(WR_BEATS - 1);

    typedef enum logic [0:0] {StIdle, StWdata} state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic [CntBits-1:0]   beat_cnt_q, beat_cnt_d;

    logic                 sel;
    logic                 any_valid;
    logic                 sel_valid;
    logic                 sel_rw;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [TAG_BITS-2:0]  sel_tag;
    logic                 own_valid;
    logic [DATA_BITS-1:0] own_bits;
    logic [MaskBits-1:0]  own_mask;
    logic                 accept;
    logic                 beat_fire;

    // Round-robin pick: on a tie the client that did not win last time goes.
    always_comb begin
        sel       = 1'b0;
        any_valid = bus.ic_req_valid | bus.dc_req_valid;
        if (bus.ic_req_valid && bus.dc_req_valid) begin
            sel = ~last_grant_q;
        end else if (bus.dc_req_valid) begin
            sel = 1'b1;
        end
    end

    // Request mux from the selected client and data mux from the write owner.
    always_comb begin
        sel_valid = sel ? bus.dc_req_valid : bus.ic_req_valid;
        sel_rw    = sel ? bus.dc_req_rw    : bus.ic_req_rw;
        sel_addr  = sel ? bus.dc_req_addr  : bus.ic_req_addr;
        sel_tag   = sel ? bus.dc_req_tag   : bus.ic_req_tag;
        own_valid = owner_q ? bus.dc_req_data_valid : bus.ic_req_data_valid;
        own_bits  = owner_q ? bus.dc_req_data_bits  : bus.ic_req_data_bits;
        own_mask  = owner_q ? bus.dc_req_data_mask  : bus.ic_req_data_mask;
    end

    // Next-state and handshake outputs; every valid/ready is held low in reset.
    always_comb begin
        state_d                = state_q;
        last_grant_d           = last_grant_q;
        owner_d                = owner_q;
        beat_cnt_d             = beat_cnt_q;
        accept                 = 1'b0;
        beat_fire              = 1'b0;
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_rw         = sel_rw;
        bus.mem_req_addr       = sel_addr;
        bus.mem_req_tag        = {sel, sel_tag};
        bus.ic_req_ready       = 1'b0;
        bus.dc_req_ready       = 1'b0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = own_bits;
        bus.mem_req_data_mask  = own_mask;
        bus.ic_req_data_ready  = 1'b0;
        bus.dc_req_data_ready  = 1'b0;

        if (reset_n) begin
            unique case (state_q)
                StIdle: begin
                    bus.mem_req_valid = sel_valid;
                    // With no client requesting nobody is selected, so no ready.
                    bus.ic_req_ready  = any_valid & ~sel & bus.mem_req_ready;
                    bus.dc_req_ready  = any_valid &  sel & bus.mem_req_ready;
                    accept            = sel_valid & bus.mem_req_ready;
                    if (accept) begin
                        last_grant_d = sel;
                        if (sel_rw) begin
                            owner_d    = sel;
                            beat_cnt_d = '0;
                            state_d    = StWdata;
                        end
                    end
                end
                StWdata: begin
                    bus.mem_req_data_valid = own_valid;
                    bus.ic_req_data_ready  = ~owner_q & bus.mem_req_data_ready;
                    bus.dc_req_data_ready  =  owner_q & bus.mem_req_data_ready;
                    beat_fire              = own_valid & bus.mem_req_data_ready;
                    if (beat_fire) begin
                        if (beat_cnt_q == LastBeat) begin
                            beat_cnt_d = '0;
                            state_d    = StIdle;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Response steering by tag MSB, independent of the request-side state.
    always_comb begin
        bus.ic_resp_valid = reset_n & bus.mem_resp_valid & ~bus.mem_resp_tag[TAG_BITS-1];
        bus.dc_resp_valid = reset_n & bus.mem_resp_valid &  bus.mem_resp_tag[TAG_BITS-1];
        bus.ic_resp_tag   = bus.mem_resp_tag[TAG_BITS-2:0];
        bus.dc_resp_tag   = bus.mem_resp_tag[TAG_BITS-2:0];
        bus.ic_resp_data  = bus.mem_resp_data;
        bus.dc_resp_data  = bus.mem_resp_data;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ic_q, perf_dc_q, perf_cf_q;

    // Wrapping event counters for grants and tie cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_ic_q <= '0;
            perf_dc_q <= '0;
            perf_cf_q <= '0;
        end else begin
            if (accept && !sel) perf_ic_q <= perf_ic_q + 32'd1;
            if (accept &&  sel) perf_dc_q <= perf_dc_q + 32'd1;
            if (state_q == StIdle && bus.ic_req_valid && bus.dc_req_valid) begin
                perf_cf_q <= perf_cf_q + 32'd1;
            end
        end
    end

    assign perf_ic_grants       = perf_ic_q;
    assign perf_dc_grants       = perf_dc_q;
    assign perf_conflict_cycles = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: table of single-cycle read/response
// vectors, then hand-written write-burst, mid-burst reset and counter sequences.
module tb_mem_req_arbiter;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned TW = 5;
    localparam int unsigned WB = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] p_ic, p_dc, p_cf;
`endif

    mem_req_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW), .WR_BEATS(WB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_ic_grants       (p_ic),
        .perf_dc_grants       (p_dc),
        .perf_conflict_cycles (p_cf)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.ic_req_valid = 1'b0; bus.ic_req_rw = 1'b0; bus.ic_req_addr = '0; bus.ic_req_tag = '0;
        bus.ic_req_data_valid = 1'b0; bus.ic_req_data_bits = '0; bus.ic_req_data_mask = '0;
        bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0; bus.dc_req_addr = '0; bus.dc_req_tag = '0;
        bus.dc_req_data_valid = 1'b0; bus.dc_req_data_bits = '0; bus.dc_req_data_mask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_tag = '0; bus.mem_resp_data = '0;
    endtask

    function automatic logic [127:0] beat_val(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + n;
        return {w, w, w, w};
    endfunction

    function automatic logic [15:0] beat_mask(input int n);
        return 16'hF000 | (16'h0001 << n);
    endfunction

    typedef struct {
        logic        ic_v;
        logic        dc_v;
        logic [3:0]  ic_tag;
        logic [3:0]  dc_tag;
        logic [27:0] ic_addr;
        logic        rdy;
        logic        rsp_v;
        logic [4:0]  rsp_tag;
        logic        e_mv;
        logic [4:0]  e_tag;
        logic [27:0] e_addr;
        logic        e_icr;
        logic        e_dcr;
        logic        e_icrv;
        logic        e_dcrv;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    logic [127:0] rsp_data;
    logic [127:0] junk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rsp_data = 128'hDEADBEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        junk     = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

        // dc address is fixed at 0x20; last_grant starts at 1 so ic wins the first tie.
        //            icv   dcv   ictag  dctag  ic_addr    rdy   rspv  rsptag  mv    etag   e_addr     icr   dcr   icrv  dcrv
        vecs[0]  = '{1'b0, 1'b0, 4'd0, 4'd0, 28'h10,    1'b1, 1'b1, 5'h12, 1'b0, 5'h00, 28'h0,     1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 4'd3, 4'd0, 28'h10,    1'b1, 1'b1, 5'h07, 1'b1, 5'h03, 28'h10,    1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h12, 28'h20,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h01, 28'h30,    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h12, 28'h20,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b0, 1'b0, 5'h00, 1'b1, 5'h01, 28'h30,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b0, 1'b1, 5'h1F, 1'b1, 5'h01, 28'h30,    1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h01, 28'h30,    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd0, 4'd5, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h15, 28'h20,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd0, 4'd6, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h16, 28'h20,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'd1, 4'd2, 28'h30,    1'b1, 1'b0, 5'h00, 1'b1, 5'h01, 28'h30,    1'b1, 1'b0, 1'b0, 1'b0};

        // Reset: outputs forced low even with everything asserted on the inputs.
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        bus.ic_req_valid = 1'b1; bus.ic_req_data_valid = 1'b1; bus.mem_req_ready = 1'b1;
        bus.mem_req_data_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_tag = 5'h07;
        #1;
        chk("rst mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst ic_req_ready", bus.ic_req_ready, 1'b0);
        chk("rst ic_req_data_ready", bus.ic_req_data_ready, 1'b0);
        chk("rst mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        chk("rst ic_resp_valid", bus.ic_resp_valid, 1'b0);
        tick();
        idle_inputs();
        reset_n = 1'b1;

        // Read arbitration and response routing table.
        for (int i = 0; i < NV; i++) begin
            bus.ic_req_valid = vecs[i].ic_v; bus.ic_req_rw = 1'b0;
            bus.ic_req_tag = vecs[i].ic_tag; bus.ic_req_addr = vecs[i].ic_addr;
            bus.dc_req_valid = vecs[i].dc_v; bus.dc_req_rw = 1'b0;
            bus.dc_req_tag = vecs[i].dc_tag; bus.dc_req_addr = 28'h20;
            bus.mem_req_ready = vecs[i].rdy;
            bus.mem_resp_valid = vecs[i].rsp_v; bus.mem_resp_tag = vecs[i].rsp_tag;
            bus.mem_resp_data = rsp_data;
            #1;
            chk($sformatf("v%0d mem_req_valid", i), bus.mem_req_valid, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d mem_req_tag", i), bus.mem_req_tag, vecs[i].e_tag);
                chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr, vecs[i].e_addr);
                chk($sformatf("v%0d mem_req_rw", i), bus.mem_req_rw, 1'b0);
            end
            chk($sformatf("v%0d ic_req_ready", i), bus.ic_req_ready, vecs[i].e_icr);
            chk($sformatf("v%0d dc_req_ready", i), bus.dc_req_ready, vecs[i].e_dcr);
            chk($sformatf("v%0d ic_resp_valid", i), bus.ic_resp_valid, vecs[i].e_icrv);
            chk($sformatf("v%0d dc_resp_valid", i), bus.dc_resp_valid, vecs[i].e_dcrv);
            if (vecs[i].rsp_v) begin
                chk($sformatf("v%0d ic_resp_tag", i), bus.ic_resp_tag, vecs[i].rsp_tag[3:0]);
                chk($sformatf("v%0d dc_resp_tag", i), bus.dc_resp_tag, vecs[i].rsp_tag[3:0]);
            end
            chk($sformatf("v%0d mem_req_data_valid", i), bus.mem_req_data_valid, 1'b0);
            tick();
        end
        idle_inputs();

        // dc write burst: last grant was ic, so dc wins the tie.
        bus.ic_req_valid = 1'b1; bus.ic_req_rw = 1'b0; bus.ic_req_addr = 28'h30; bus.ic_req_tag = 4'd1;
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b1; bus.dc_req_addr = 28'h40; bus.dc_req_tag = 4'd4;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("wr mem_req_valid", bus.mem_req_valid, 1'b1);
        chk("wr mem_req_rw", bus.mem_req_rw, 1'b1);
        chk("wr mem_req_tag", bus.mem_req_tag, 5'h14);
        chk("wr mem_req_addr", bus.mem_req_addr, 28'h40);
        chk("wr dc_req_ready", bus.dc_req_ready, 1'b1);
        chk("wr ic_req_ready", bus.ic_req_ready, 1'b0);
        tick();
        begin
            int   nb;
            logic dr;
            nb = 0;
            dr = 1'b1;
            bus.dc_req_valid = 1'b0;
            bus.dc_req_data_valid = 1'b1;
            bus.ic_req_data_valid = 1'b1; bus.ic_req_data_bits = junk; bus.ic_req_data_mask = 16'hFFFF;
            for (int c = 0; c < 20 && nb < WB; c++) begin
                bus.mem_req_data_ready = dr;
                bus.dc_req_data_bits = beat_val(nb);
                bus.dc_req_data_mask = beat_mask(nb);
                bus.mem_resp_valid = (c == 1);
                bus.mem_resp_tag = 5'h12;
                bus.mem_resp_data = rsp_data;
                #1;
                chk($sformatf("wd%0d mem_req_valid", c), bus.mem_req_valid, 1'b0);
                chk($sformatf("wd%0d ic_req_ready", c), bus.ic_req_ready, 1'b0);
                chk($sformatf("wd%0d dc_req_ready", c), bus.dc_req_ready, 1'b0);
                chk($sformatf("wd%0d mem_req_data_valid", c), bus.mem_req_data_valid, 1'b1);
                chk($sformatf("wd%0d dc_req_data_ready", c), bus.dc_req_data_ready, dr);
                chk($sformatf("wd%0d ic_req_data_ready", c), bus.ic_req_data_ready, 1'b0);
                if (c == 1) begin
                    chk("rsp dc_resp_valid", bus.dc_resp_valid, 1'b1);
                    chk("rsp dc_resp_tag", bus.dc_resp_tag, 4'h2);
                    chk("rsp dc_resp_data", bus.dc_resp_data, rsp_data);
                    chk("rsp ic_resp_valid", bus.ic_resp_valid, 1'b0);
                end
                if (dr) begin
                    chk($sformatf("wd beat%0d bits", nb), bus.mem_req_data_bits, beat_val(nb));
                    chk($sformatf("wd beat%0d mask", nb), bus.mem_req_data_mask, beat_mask(nb));
                    nb++;
                end
                dr = ~dr;
                tick();
            end
            chk("wd beats seen", nb, WB);
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_data_ready = 1'b1;
        #1;
        chk("post-wr ic_req_ready", bus.ic_req_ready, 1'b1);
        chk("post-wr mem_req_tag", bus.mem_req_tag, 5'h01);
        chk("post-wr mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        chk("post-wr dc_req_data_ready", bus.dc_req_data_ready, 1'b0);
        tick();
        idle_inputs();

        // ic write interrupted by reset after two beats.
        bus.ic_req_valid = 1'b1; bus.ic_req_rw = 1'b1; bus.ic_req_addr = 28'h50; bus.ic_req_tag = 4'd7;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("icw ic_req_ready", bus.ic_req_ready, 1'b1);
        chk("icw mem_req_tag", bus.mem_req_tag, 5'h07);
        tick();
        bus.ic_req_valid = 1'b0;
        bus.ic_req_data_valid = 1'b1; bus.mem_req_data_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.ic_req_data_bits = beat_val(b);
            bus.ic_req_data_mask = beat_mask(b);
            #1;
            chk($sformatf("icw beat%0d data_valid", b), bus.mem_req_data_valid, 1'b1);
            chk($sformatf("icw beat%0d data_ready", b), bus.ic_req_data_ready, 1'b1);
            chk($sformatf("icw beat%0d bits", b), bus.mem_req_data_bits, beat_val(b));
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("midrst mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        chk("midrst ic_req_data_ready", bus.ic_req_data_ready, 1'b0);
        tick();
        reset_n = 1'b1;
        bus.ic_req_valid = 1'b1; bus.ic_req_rw = 1'b0; bus.ic_req_addr = 28'h60; bus.ic_req_tag = 4'd2;
        #1;
        chk("afterrst mem_req_valid", bus.mem_req_valid, 1'b1);
        chk("afterrst ic_req_ready", bus.ic_req_ready, 1'b1);
        chk("afterrst mem_req_tag", bus.mem_req_tag, 5'h02);
        chk("afterrst mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        chk("afterrst ic_req_data_ready", bus.ic_req_data_ready, 1'b0);
        tick();
        bus.ic_req_valid = 1'b0;
        #1;
        chk("afterrd mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
        idle_inputs();

`ifdef MEM_ARB_PERF_EN
        // Ten tie cycles from a fresh reset split the grants evenly.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("perf clr conflict", p_cf, 32'd0);
        chk("perf clr ic", p_ic, 32'd0);
        bus.ic_req_valid = 1'b1; bus.dc_req_valid = 1'b1; bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        idle_inputs();
        #1;
        chk("perf conflict", p_cf, 32'd10);
        chk("perf ic grants", p_ic, 32'd5);
        chk("perf dc grants", p_dc, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
